// File: rtl/floo_sl_arb_pkg.sv
// Shared types and helpers for the serial-link flit arbiter.
package floo_sl_arb_pkg;

   // Channel tag carried with every output flit.
   typedef enum logic [1:0] {
      NREQ = 2'd0,
      NRSP = 2'd1,
      WIDE = 2'd2
   } chan_id_e;

   localparam int NumArbChannels = 3;

   // Largest of three widths; sizes the merged output payload.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Round-robin successor over the three channels.
   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/floo_sl_rr_lock_arb.sv
// Round-robin arbiter with wormhole lock: once a packet starts, only its
// channel is granted until the flit carrying last is handed over.
import floo_sl_arb_pkg::*;

module floo_sl_rr_lock_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [2:0] last,
   input  logic       hs,
   output logic [2:0] gnt
);

   typedef enum logic {IDLE, LOCKED} arb_state_e;

   arb_state_e state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] lock_q, lock_d;
   logic [1:0] gnt_idx;
   logic [1:0] idx;
   logic       found;

   // Grant selection and next-state: search from the pointer in IDLE, hold the locked channel otherwise.
   always_comb begin
      gnt     = '0;
      gnt_idx = ptr_q;
      idx     = ptr_q;
      found   = 1'b0;
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      if (state_q == LOCKED) begin
         gnt[lock_q] = req[lock_q];
         gnt_idx     = lock_q;
      end else begin
         for (int i = 0; i < NumArbChannels; i++) begin
            if (!found && req[idx]) begin
               found   = 1'b1;
               gnt_idx = idx;
            end
            idx = rr_next(idx);
         end
         gnt[gnt_idx] = found;
      end
      // The pointer only moves on an actual transfer, so a stalled offer keeps its priority.
      if (hs) begin
         if (last[gnt_idx]) begin
            state_d = IDLE;
            ptr_d   = rr_next(gnt_idx);
         end else begin
            state_d = LOCKED;
            lock_d  = gnt_idx;
         end
      end
   end

   // State, pointer and lock registers; reset restarts from nreq priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         lock_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
      end
   end

endmodule

// File: rtl/floo_sl_flit_arbiter.sv
// Merges narrow req, narrow rsp and wide flit streams into one registered,
// channel-tagged stream with saturating per-channel flit counters.
import floo_sl_arb_pkg::*;

module floo_sl_flit_arbiter #(
   parameter  int NarrowReqWidth = 64,
   parameter  int NarrowRspWidth = 64,
   parameter  int WideWidth      = 512,
   parameter  int CntWidth       = 16,
   localparam int OutWidth       = max3(NarrowReqWidth, NarrowRspWidth, WideWidth)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      clear_cnt_i,
   input  logic                      nreq_valid_i,
   output logic                      nreq_ready_o,
   input  logic                      nreq_last_i,
   input  logic [NarrowReqWidth-1:0] nreq_data_i,
   input  logic                      nrsp_valid_i,
   output logic                      nrsp_ready_o,
   input  logic                      nrsp_last_i,
   input  logic [NarrowRspWidth-1:0] nrsp_data_i,
   input  logic                      wide_valid_i,
   output logic                      wide_ready_o,
   input  logic                      wide_last_i,
   input  logic [WideWidth-1:0]      wide_data_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [1:0]                chan_o,
   output logic [OutWidth-1:0]       data_o,
   output logic                      last_o,
   output logic [3*CntWidth-1:0]     cnt_o
);

   logic                can_accept;
   logic                hs;
   logic [2:0]          gnt;
   logic [2:0]          hs_vec;
   logic [OutWidth-1:0] data_sel;
   chan_id_e            chan_sel;
   logic                last_sel;

   logic                vld_p0;
   chan_id_e            chan_p0;
   logic [OutWidth-1:0] data_p0;
   logic                last_p0;

   logic [CntWidth-1:0] cnt_q [NumArbChannels];

   floo_sl_rr_lock_arb i_arb (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .req   ({wide_valid_i, nrsp_valid_i, nreq_valid_i}),
      .last  ({wide_last_i, nrsp_last_i, nreq_last_i}),
      .hs    (hs),
      .gnt   (gnt)
   );

   // Ready is gated by reset because the grant itself is purely combinational on valid.
   assign can_accept   = !vld_p0 || ready_i;
   assign hs           = (|gnt) && can_accept && rst_ni;
   assign nreq_ready_o = gnt[0] && can_accept && rst_ni;
   assign nrsp_ready_o = gnt[1] && can_accept && rst_ni;
   assign wide_ready_o = gnt[2] && can_accept && rst_ni;
   assign hs_vec       = {wide_valid_i && wide_ready_o,
                          nrsp_valid_i && nrsp_ready_o,
                          nreq_valid_i && nreq_ready_o};

   // Mux the granted channel and zero-extend narrow payloads to the output width.
   always_comb begin
      data_sel = '0;
      chan_sel = NREQ;
      last_sel = 1'b0;
      if (gnt[0]) begin
         data_sel[NarrowReqWidth-1:0] = nreq_data_i;
         chan_sel                     = NREQ;
         last_sel                     = nreq_last_i;
      end else if (gnt[1]) begin
         data_sel[NarrowRspWidth-1:0] = nrsp_data_i;
         chan_sel                     = NRSP;
         last_sel                     = nrsp_last_i;
      end else if (gnt[2]) begin
         data_sel[WideWidth-1:0] = wide_data_i;
         chan_sel                = WIDE;
         last_sel                = wide_last_i;
      end
   end

   // ---- stage p0: output register, held stable while downstream stalls ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p0  <= 1'b0;
         chan_p0 <= NREQ;
         data_p0 <= '0;
         last_p0 <= 1'b0;
      end else if (can_accept) begin
         vld_p0 <= hs;
         if (hs) begin
            chan_p0 <= chan_sel;
            data_p0 <= data_sel;
            last_p0 <= last_sel;
         end
      end
   end

   assign valid_o = vld_p0;
   assign chan_o  = chan_p0;
   assign data_o  = data_p0;
   assign last_o  = last_p0;

   // Per-channel accepted-flit counters; clear beats increment, saturate at all ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int c = 0; c < NumArbChannels; c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < NumArbChannels; c++) begin
            if (clear_cnt_i) begin
               cnt_q[c] <= '0;
            end else if (hs_vec[c] && (cnt_q[c] != '1)) begin
               cnt_q[c] <= cnt_q[c] + 1'b1;
            end
         end
      end
   end

   // Flatten the counters onto the debug port.
   always_comb begin
      cnt_o = '0;
      for (int c = 0; c < NumArbChannels; c++) cnt_o[c*CntWidth +: CntWidth] = cnt_q[c];
   end

endmodule

// File: tb/tb_floo_sl_flit_arbiter.sv
// Directed bench with a scoreboard for floo_sl_flit_arbiter.
module tb_floo_sl_flit_arbiter;

   localparam int NRW = 64;
   localparam int NSW = 64;
   localparam int WW  = 512;
   localparam int CW  = 4;
   localparam int OW  = 512;

   typedef struct packed {
      logic [1:0]    chan;
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct packed {
      logic [WW-1:0] data;
      logic          last;
   } src_t;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            clear_cnt_i;
   logic            nreq_valid_i, nreq_ready_o, nreq_last_i;
   logic [NRW-1:0]  nreq_data_i;
   logic            nrsp_valid_i, nrsp_ready_o, nrsp_last_i;
   logic [NSW-1:0]  nrsp_data_i;
   logic            wide_valid_i, wide_ready_o, wide_last_i;
   logic [WW-1:0]   wide_data_i;
   logic            valid_o, ready_i, last_o;
   logic [1:0]      chan_o;
   logic [OW-1:0]   data_o;
   logic [3*CW-1:0] cnt_o;

   exp_t exp_q[$];
   src_t src0[$], src1[$], src2[$];
   int   pop_cyc[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   logic [2:0] s_hs;

   floo_sl_flit_arbiter #(
      .NarrowReqWidth (NRW),
      .NarrowRspWidth (NSW),
      .WideWidth      (WW),
      .CntWidth       (CW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .clear_cnt_i  (clear_cnt_i),
      .nreq_valid_i (nreq_valid_i),
      .nreq_ready_o (nreq_ready_o),
      .nreq_last_i  (nreq_last_i),
      .nreq_data_i  (nreq_data_i),
      .nrsp_valid_i (nrsp_valid_i),
      .nrsp_ready_o (nrsp_ready_o),
      .nrsp_last_i  (nrsp_last_i),
      .nrsp_data_i  (nrsp_data_i),
      .wide_valid_i (wide_valid_i),
      .wide_ready_o (wide_ready_o),
      .wide_last_i  (wide_last_i),
      .wide_data_i  (wide_data_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .chan_o       (chan_o),
      .data_o       (data_o),
      .last_o       (last_o),
      .cnt_o        (cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [WW-1:0] wdat(input int k);
      logic [WW-1:0] w;
      w = '0;
      w[511:448] = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      w[15:0]    = 16'hC000 | 16'(k);
      return w;
   endfunction

   function automatic logic [CW-1:0] cnt_of(input int c);
      return cnt_o[c*CW +: CW];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Present the head of each source queue on its channel.
   task automatic apply();
      nreq_valid_i = (src0.size() > 0);
      nreq_data_i  = (src0.size() > 0) ? src0[0].data[NRW-1:0] : '0;
      nreq_last_i  = (src0.size() > 0) ? src0[0].last : 1'b0;
      nrsp_valid_i = (src1.size() > 0);
      nrsp_data_i  = (src1.size() > 0) ? src1[0].data[NSW-1:0] : '0;
      nrsp_last_i  = (src1.size() > 0) ? src1[0].last : 1'b0;
      wide_valid_i = (src2.size() > 0);
      wide_data_i  = (src2.size() > 0) ? src2[0].data : '0;
      wide_last_i  = (src2.size() > 0) ? src2[0].last : 1'b0;
   endtask

   task automatic push_src(input int c, input logic [WW-1:0] d, input logic l);
      src_t s;
      s.data = d;
      s.last = l;
      if (c == 0) src0.push_back(s);
      else if (c == 1) src1.push_back(s);
      else src2.push_back(s);
      apply();
   endtask

   task automatic push_exp(input int c, input logic [OW-1:0] d, input logic l);
      exp_t e;
      e.chan = 2'(c);
      e.data = d;
      e.last = l;
      exp_q.push_back(e);
   endtask

   // One clock: sample input handshakes mid-cycle, advance sources after the edge.
   task automatic tick();
      @(negedge clk);
      s_hs = {wide_valid_i && wide_ready_o, nrsp_valid_i && nrsp_ready_o,
              nreq_valid_i && nreq_ready_o};
      @(posedge clk);
      #1;
      if (s_hs[0]) void'(src0.pop_front());
      if (s_hs[1]) void'(src1.pop_front());
      if (s_hs[2]) void'(src2.pop_front());
      apply();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d flits outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Output monitor: pops the scoreboard on every output transfer.
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_ni && valid_o && ready_i) begin
            pop_cyc.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_flit: got chan=%0d data=%h, expected none", chan_o, data_o);
            end else begin
               e = exp_q.pop_front();
               if (chan_o !== e.chan || data_o !== e.data || last_o !== e.last) begin
                  miscompares++;
                  $display("FAIL flit: got chan=%0d last=%0d data=%h expected chan=%0d last=%0d data=%h",
                           chan_o, last_o, data_o, e.chan, e.last, e.data);
               end
            end
         end
      end
   endtask

   initial begin
      int base;
      fork
         monitor();
      join_none

      rst_ni      = 1'b0;
      clear_cnt_i = 1'b0;
      ready_i     = 1'b1;
      apply();
      nreq_valid_i = 1'b1;
      wide_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_chan", chan_o, 0);
      chk("rst_data_zero", data_o == '0, 1);
      chk("rst_last", last_o, 0);
      chk("rst_ready", {nreq_ready_o, nrsp_ready_o, wide_ready_o}, 0);
      chk("rst_cnt", cnt_o, 0);
      apply();
      rst_ni = 1'b1;

      // Round robin over three always-valid single-flit streams.
      for (int k = 0; k < 2; k++) begin
         push_src(0, 'h100 + k, 1'b1);
         push_src(1, 'h200 + k, 1'b1);
         push_src(2, wdat(k), 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
         push_exp(0, 'h100 + k, 1'b1);
         push_exp(1, 'h200 + k, 1'b1);
         push_exp(2, wdat(k), 1'b1);
      end
      base = pop_cyc.size();
      drain(50);
      chk("t1_back_to_back", (pop_cyc.size() >= base + 6) ? pop_cyc[base+5] - pop_cyc[base] : -1, 5);
      chk("t1_cnt_nreq", cnt_of(0), 2);
      chk("t1_cnt_nrsp", cnt_of(1), 2);
      chk("t1_cnt_wide", cnt_of(2), 2);

      // Wide 4-flit packet holds the lock against a later nreq.
      for (int k = 10; k < 14; k++) push_src(2, wdat(k), (k == 13));
      for (int k = 10; k < 14; k++) push_exp(2, wdat(k), (k == 13));
      push_exp(0, 'h300, 1'b1);
      tick();
      push_src(0, 'h300, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("t2_nreq_ready_locked", nreq_ready_o, 0);
         chk("t2_wide_ready_locked", wide_ready_o, 1);
         tick();
      end
      drain(50);

      // Backpressure: output held stable, no input accepted, no counting.
      ready_i = 1'b0;
      push_src(1, 'hA5, 1'b1);
      push_src(1, 'h5A, 1'b1);
      push_exp(1, 'hA5, 1'b1);
      push_exp(1, 'h5A, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", valid_o, 1);
         chk("t3_hold_data", data_o[63:0], 64'hA5);
         chk("t3_hold_chan", chan_o, 1);
         chk("t3_no_ready", {nreq_ready_o, nrsp_ready_o, wide_ready_o}, 0);
         chk("t3_cnt_nrsp", cnt_of(1), 3);
         tick();
      end
      ready_i = 1'b1;
      base = pop_cyc.size();
      drain(50);
      chk("t3_next_flit_gap", (pop_cyc.size() >= base + 2) ? pop_cyc[base+1] - pop_cyc[base] : -1, 1);

      // Zero extension of a narrow payload.
      push_src(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      push_exp(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      drain(20);

      // Counter saturation, then clear together with a handshake.
      for (int k = 0; k < 20; k++) push_src(0, 'h400 + k, 1'b1);
      for (int k = 0; k < 20; k++) push_exp(0, 'h400 + k, 1'b1);
      drain(100);
      chk("t5_cnt_saturated", cnt_of(0), 15);
      push_src(0, 'h500, 1'b1);
      push_exp(0, 'h500, 1'b1);
      clear_cnt_i = 1'b1;
      tick();
      clear_cnt_i = 1'b0;
      chk("t5_clear_wins", cnt_of(0), 0);
      chk("t5_clear_all", cnt_o, 0);
      drain(20);

      // Async reset in the middle of a locked nrsp packet.
      push_src(1, 'h600, 1'b0);
      push_src(1, 'h601, 1'b0);
      push_src(1, 'h602, 1'b1);
      push_exp(1, 'h600, 1'b0);
      tick();
      tick();
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", valid_o, 0);
      chk("t6_rst_chan", chan_o, 0);
      chk("t6_rst_data_zero", data_o == '0, 1);
      chk("t6_rst_last", last_o, 0);
      chk("t6_rst_ready", nrsp_ready_o, 0);
      chk("t6_rst_cnt", cnt_o, 0);
      chk("t6_scoreboard_empty", exp_q.size(), 0);
      src0.delete();
      src1.delete();
      src2.delete();
      apply();
      tick();
      tick();
      rst_ni = 1'b1;
      push_src(0, 'h700, 1'b1);
      push_src(1, 'h710, 1'b1);
      push_src(2, wdat(7), 1'b1);
      push_exp(0, 'h700, 1'b1);
      push_exp(1, 'h710, 1'b1);
      push_exp(2, wdat(7), 1'b1);
      drain(30);
      chk("t6_cnt_after", cnt_o, {4'd1, 4'd1, 4'd1});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/floo_sl_flit_arbiter.md
Name: floo_sl_flit_arbiter

Overview:
- Upstream feeder for the narrow/wide serial link in single-lane-group configurations.
- Merges the narrow request, narrow response and wide flit streams into one tagged flit stream.
- Arbitration is round-robin and wormhole-locked: a multi-flit packet is never interleaved.
- Output is registered, and the block keeps saturating per-channel flit counters for debug and perf.

Parameters:
- NarrowReqWidth, 64, payload bits of a narrow request flit.
- NarrowRspWidth, 64, payload bits of a narrow response flit.
- WideWidth, 512, payload bits of a wide flit.
- OutWidth, max(NarrowReqWidth, NarrowRspWidth, WideWidth), output payload width; derived, must not be overridden.
- CntWidth, 16, width of each flit counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_cnt_i  in  1  synchronous clear of all counters
- nreq_valid_i / nreq_ready_o / nreq_last_i  in/out/in  1  narrow req handshake, end-of-packet
- nreq_data_i  in  NarrowReqWidth  narrow req payload
- nrsp_valid_i / nrsp_ready_o / nrsp_last_i  in/out/in  1  narrow rsp handshake, end-of-packet
- nrsp_data_i  in  NarrowRspWidth  narrow rsp payload
- wide_valid_i / wide_ready_o / wide_last_i  in/out/in  1  wide handshake, end-of-packet
- wide_data_i  in  WideWidth  wide payload
- valid_o  out  1  output flit valid
- ready_i  in  1  downstream ready
- chan_o  out  2  channel tag: 0=nreq, 1=nrsp, 2=wide (3 never driven)
- data_o  out  OutWidth  zero-extended payload
- last_o  out  1  end-of-packet
- cnt_o  out  3*CntWidth  accepted-flit counters; [0]=nreq, [1]=nrsp, [2]=wide

Behaviour:
- Reset (async, rst_ni=0):
  - valid_o=0, chan_o=0, data_o=0, last_o=0.
  - RR pointer=0, lock cleared, all counters 0.
  - All *_ready_o=0 while in reset.
- Output stage: single pipeline register.
  - Accept condition: can_accept = !valid_o | ready_i.
  - Latency exactly 1 cycle from input handshake to valid_o.
  - Full throughput: 1 flit/cycle under continuous ready_i.
- Handshakes (AXI-style):
  - An input handshake occurs when valid & ready are both high.
  - ready_o is combinational: high only on the granted channel, and only when can_accept=1.
  - No ready_o is asserted without an active grant.
  - Once valid_o=1, the output register holds data_o/chan_o/last_o stable until ready_i=1.
- Arbitration FSM, states IDLE and LOCKED:
  - IDLE: among valid inputs, grant the first found searching from the RR pointer upward, mod 3.
  - Grant issued, handshake with last=1: transfer completes in the same cycle; stay IDLE; pointer=(granted+1) mod 3.
  - Grant issued, handshake with last=0: go to LOCKED, remembering the granted channel.
  - LOCKED: only the locked channel may be granted; the other channels' valids are ignored.
  - LOCKED exit: on a handshake with last=1 -> IDLE, pointer=(locked+1) mod 3.
  - LOCKED while the locked channel deasserts valid: stay LOCKED with no output; wormhole is never broken.
  - Grant in IDLE is recomputed every cycle. A grant offered while can_accept=0 does not move the pointer.
- Width: narrower payloads are zero-extended into data_o; upper bits are always 0 for narrow channels.
- Counters:
  - Increment the channel's counter on every input handshake.
  - Saturate at 2^CntWidth-1; no wrap.
  - clear_cnt_i zeroes all counters next cycle and wins over a simultaneous increment.
- Reset mid-packet: lock and pointer are discarded; after release, arbitration restarts from nreq priority.

Decomposition:
- Shared package floo_sl_arb_pkg holds:
  - chan_id_e enum (NREQ=0, NRSP=1, WIDE=2).
  - NumArbChannels=3.
  - Function max3() for OutWidth.
- One natural sub-module: floo_sl_rr_lock_arb.
  - Contains the RR pointer and IDLE/LOCKED FSM.
  - Inputs: req[2:0], last[2:0], handshake strobe.
  - Outputs: one-hot gnt[2:0].
- The top level holds the output register, zero-extension and counters.

Test Plan:
- Reset release, then all three valids high with last=1 and ready_i=1 -> chan_o sequence 0,1,2,0,1,2 on consecutive cycles; valid_o continuous; cnt_o each =2 after 6 flits.
- Wide 4-flit packet (last on 4th) starts at cycle 0; nreq valid from cycle 1 -> chan_o=2 for 4 consecutive flits, then chan_o=0; nreq_ready_o=0 throughout the lock.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1, data_o=0xA5 -> data_o/chan_o stable; all *_ready_o=0; no counter change; ready_i=1 -> 0xA5 taken, next flit follows 1 cycle later.
- Zero-extension: nrsp_data_i=64'hFFFF_FFFF_FFFF_FFFF -> data_o[63:0] all ones, data_o[511:64]=0, chan_o=1.
- Saturation/clear: CntWidth=4, 20 nreq flits -> cnt_o[0]=15; clear_cnt_i pulsed together with a handshake -> cnt_o[0]=0.
- Async reset asserted while LOCKED on nrsp mid-packet -> outputs 0 immediately; after release with all valid -> first grant nreq (chan_o=0).
